// File: rtl/flitzip_pkg.sv
// Shared sizing helpers and stage control type for the FlitZip base-delta compressor.
package flitzip_pkg;

   function automatic int num_chunks(input int flit_width, input int chunk_size);
      return flit_width / chunk_size;
   endfunction

   function automatic int len_w(input int flit_width);
      return $clog2(flit_width + 1);
   endfunction

   // Encoding value reserved for raw pass-through flits.
   function automatic int en_raw(input int en_bits);
      return (1 << en_bits) - 1;
   endfunction

   typedef struct packed {
      logic vld;
      logic raw;
   } stage_ctl_t;

endpackage

// File: rtl/chunk_minmax.sv
// Combinational max/min reduction tree over N unsigned chunks.
module chunk_minmax #(
   parameter int N          = 16,
   parameter int CHUNK_SIZE = 8
) (
   input  logic [N*CHUNK_SIZE-1:0] data,
   output logic [CHUNK_SIZE-1:0]   max_val,
   output logic [CHUNK_SIZE-1:0]   min_val
);

   localparam int LV = $clog2(N);
   localparam int P  = 1 << LV;

   // Leaves beyond N are padded with chunk 0, which is neutral for both max and min.
   for (genvar l = 0; l <= LV; l++) begin : lvl
      localparam int W = P >> l;
      logic [CHUNK_SIZE-1:0] mx [W];
      logic [CHUNK_SIZE-1:0] mn [W];
      for (genvar i = 0; i < W; i++) begin : node
         if (l == 0) begin : leaf
            localparam int SRC = (i < N) ? i : 0;
            assign mx[i] = data[SRC*CHUNK_SIZE +: CHUNK_SIZE];
            assign mn[i] = data[SRC*CHUNK_SIZE +: CHUNK_SIZE];
         end else begin : cmp
            assign mx[i] = (lvl[l-1].mx[2*i] > lvl[l-1].mx[2*i+1]) ? lvl[l-1].mx[2*i] : lvl[l-1].mx[2*i+1];
            assign mn[i] = (lvl[l-1].mn[2*i] < lvl[l-1].mn[2*i+1]) ? lvl[l-1].mn[2*i] : lvl[l-1].mn[2*i+1];
         end
      end
   end

   assign max_val = lvl[LV].mx[0];
   assign min_val = lvl[LV].mn[0];

endmodule

// File: rtl/flit_compressor_pipe.sv
// Three-stage base-delta flit compressor with raw fallback, global stall and delivery counters.
module flit_compressor_pipe
   import flitzip_pkg::*;
#(
   parameter int FLIT_WIDTH = 128,
   parameter int CHUNK_SIZE = 8,
   parameter int EN_BITS    = 3,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [FLIT_WIDTH-1:0]              in_data,
   input  logic                               cfg_force_raw,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [FLIT_WIDTH-1:0]              out_data,
   output logic [EN_BITS-1:0]                 out_en,
   output logic [CHUNK_SIZE-1:0]              out_base,
   output logic [$clog2(FLIT_WIDTH+1)-1:0]    out_len,
   input  logic                               stat_clr,
   output logic [CNT_WIDTH-1:0]               cnt_comp,
   output logic [CNT_WIDTH-1:0]               cnt_raw
);

   localparam int N     = num_chunks(FLIT_WIDTH, CHUNK_SIZE);
   localparam int LEN_W = len_w(FLIT_WIDTH);
   localparam int M_W   = EN_BITS + 1;
   localparam logic [EN_BITS-1:0] EN_RAW = EN_BITS'(en_raw(EN_BITS));

   // Handshake: a transfer happens on a rising edge where valid && ready; valid never
   // depends on ready, and once out_valid is high all out_* hold until out_ready.
   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // ---------------- S1: flit, force bit, min/max
   logic [CHUNK_SIZE-1:0] in_max, in_min;
   chunk_minmax #(.N(N), .CHUNK_SIZE(CHUNK_SIZE)) u_minmax (
      .data    (in_data),
      .max_val (in_max),
      .min_val (in_min)
   );

   stage_ctl_t            s1_ctl;
   logic [FLIT_WIDTH-1:0] s1_data;
   logic [CHUNK_SIZE-1:0] s1_max, s1_min;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_ctl  <= '0;
         s1_data <= '0;
         s1_max  <= '0;
         s1_min  <= '0;
      end else if (adv) begin
         s1_ctl  <= '{vld: in_valid, raw: cfg_force_raw};
         s1_data <= in_data;
         s1_max  <= in_max;
         s1_min  <= in_min;
      end
   end

   // ---------------- S2: base, delta magnitude, deltas
   logic [CHUNK_SIZE:0]              sum;
   logic [CHUNK_SIZE-1:0]            s1_base, span;
   logic [M_W-1:0]                   s1_m;
   logic [N-1:0][CHUNK_SIZE-1:0]     s1_delta;
   logic                             s1_raw;

   always_comb begin
      sum     = {1'b0, s1_max} + {1'b0, s1_min};
      s1_base = sum[CHUNK_SIZE:1];
      span    = s1_max - s1_base;
      s1_m    = '0;
      for (int b = 0; b < CHUNK_SIZE; b++)
         if (span[b]) s1_m = M_W'(b + 1);
      for (int i = 0; i < N; i++)
         s1_delta[i] = s1_data[i*CHUNK_SIZE +: CHUNK_SIZE] - s1_base;
      s1_raw = s1_ctl.raw || (s1_m >= M_W'(CHUNK_SIZE - 1));
   end

   stage_ctl_t                   s2_ctl;
   logic [FLIT_WIDTH-1:0]        s2_data;
   logic [CHUNK_SIZE-1:0]        s2_base;
   logic [M_W-1:0]               s2_m;
   logic [N-1:0][CHUNK_SIZE-1:0] s2_delta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_ctl   <= '0;
         s2_data  <= '0;
         s2_base  <= '0;
         s2_m     <= '0;
         s2_delta <= '0;
      end else if (adv) begin
         s2_ctl   <= '{vld: s1_ctl.vld, raw: s1_raw};
         s2_data  <= s1_data;
         s2_base  <= s1_base;
         s2_m     <= s1_m;
         s2_delta <= s1_delta;
      end
   end

   // ---------------- S3: pack deltas at width w = m+1 above the base
   logic [FLIT_WIDTH-1:0] pack_data;
   logic [LEN_W-1:0]      comp_len;

   always_comb begin
      pack_data                   = '0;
      pack_data[CHUNK_SIZE-1:0]   = s2_base;
      for (int wc = 1; wc < CHUNK_SIZE; wc++)
         if (int'(s2_m) + 1 == wc)
            for (int i = 0; i < N; i++)
               for (int b = 0; b < wc; b++)
                  if (CHUNK_SIZE + i*wc + b < FLIT_WIDTH)
                     pack_data[CHUNK_SIZE + i*wc + b] = s2_delta[i][b];
      comp_len = LEN_W'(CHUNK_SIZE + N * (int'(s2_m) + 1));
   end

   logic out_raw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_raw   <= 1'b0;
         out_data  <= '0;
         out_en    <= '0;
         out_base  <= '0;
         out_len   <= '0;
      end else if (adv) begin
         out_valid <= s2_ctl.vld;
         out_raw   <= s2_ctl.raw;
         out_data  <= s2_ctl.raw ? s2_data : pack_data;
         out_en    <= s2_ctl.raw ? EN_RAW : s2_m[EN_BITS-1:0];
         out_base  <= s2_ctl.raw ? '0 : s2_base;
         out_len   <= s2_ctl.raw ? LEN_W'(FLIT_WIDTH) : comp_len;
      end
   end

   // ---------------- delivery statistics; clear wins over a same-cycle increment
   logic out_hs;
   assign out_hs = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_comp <= '0;
         cnt_raw  <= '0;
      end else if (stat_clr) begin
         cnt_comp <= '0;
         cnt_raw  <= '0;
      end else if (out_hs) begin
         if (out_raw) begin
            if (cnt_raw != '1) cnt_raw <= cnt_raw + CNT_WIDTH'(1);
         end else begin
            if (cnt_comp != '1) cnt_comp <= cnt_comp + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_flit_compressor_pipe.sv
// Directed table-driven bench for flit_compressor_pipe plus stall, reset and counter sequences.
module tb_flit_compressor_pipe;

   localparam int FW = 128;
   localparam int CS = 8;
   localparam int EB = 3;
   localparam int CW = 16;
   localparam int LW = 8;
   localparam int NV = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [FW-1:0] in_data = '0;
   logic          cfg_force_raw = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [FW-1:0] out_data;
   logic [EB-1:0] out_en;
   logic [CS-1:0] out_base;
   logic [LW-1:0] out_len;
   logic          stat_clr = 1'b0;
   logic [CW-1:0] cnt_comp;
   logic [CW-1:0] cnt_raw;

   flit_compressor_pipe #(
      .FLIT_WIDTH (FW),
      .CHUNK_SIZE (CS),
      .EN_BITS    (EB),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .cfg_force_raw (cfg_force_raw),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_en        (out_en),
      .out_base      (out_base),
      .out_len       (out_len),
      .stat_clr      (stat_clr),
      .cnt_comp      (cnt_comp),
      .cnt_raw       (cnt_raw)
   );

   // ---------------- clock
   always #5 clk = ~clk;

   typedef struct {
      string         name;
      logic [FW-1:0] din;
      logic          frc;
      logic [FW-1:0] e_data;
      logic [EB-1:0] e_en;
      logic [CS-1:0] e_base;
      logic [LW-1:0] e_len;
   } vec_t;

   vec_t          vecs [NV];
   logic [FW-1:0] exp_q [$];
   int            n_chk = 0;
   int            n_pass = 0;
   int            exp_comp = 0;
   int            exp_raw = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [FW-1:0] got, input logic [FW-1:0] req);
      n_chk++;
      if (got === req) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, req);
   endtask

   // Present one table vector, measure latency to out_valid, compare all output fields.
   task automatic send_check(input int idx);
      int lat;
      in_data       = vecs[idx].din;
      cfg_force_raw = vecs[idx].frc;
      in_valid      = 1'b1;
      out_ready     = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
         if (lat == 1) begin
            in_valid      = 1'b0;
            cfg_force_raw = 1'b0;
         end
      end while (!out_valid && lat < 10);
      chk({vecs[idx].name, " latency"}, FW'(lat), FW'(3));
      chk({vecs[idx].name, " out_data"}, out_data, vecs[idx].e_data);
      chk({vecs[idx].name, " out_en"}, FW'(out_en), FW'(vecs[idx].e_en));
      chk({vecs[idx].name, " out_base"}, FW'(out_base), FW'(vecs[idx].e_base));
      chk({vecs[idx].name, " out_len"}, FW'(out_len), FW'(vecs[idx].e_len));
      if (vecs[idx].e_en == 3'd7) exp_raw++;
      else exp_comp++;
   endtask

   initial begin
      int            sent;
      int            got;
      int            cyc;
      logic          in_hs;
      logic          out_hs;
      logic          stalled_prev;
      logic [FW-1:0] prev_data;
      logic [7:0]    bv;

      vecs[0] = '{name: "uniform40", din: {16{8'h40}}, frc: 1'b0,
                  e_data: {120'h0, 8'h40}, e_en: 3'd0, e_base: 8'h40, e_len: 8'd24};
      vecs[1] = '{name: "alt10_20", din: {8{8'h20, 8'h10}}, frc: 1'b0,
                  e_data: {40'h0, {8{10'b01000_11000}}, 8'h18}, e_en: 3'd4, e_base: 8'h18, e_len: 8'd88};
      vecs[2] = '{name: "raw_00_ff", din: {{15{8'hFF}}, 8'h00}, frc: 1'b0,
                  e_data: {{15{8'hFF}}, 8'h00}, e_en: 3'd7, e_base: 8'h00, e_len: 8'd128};
      vecs[3] = '{name: "force_raw", din: {16{8'h40}}, frc: 1'b1,
                  e_data: {16{8'h40}}, e_en: 3'd7, e_base: 8'h00, e_len: 8'd128};
      vecs[4] = '{name: "alt80_81", din: {8{8'h81, 8'h80}}, frc: 1'b0,
                  e_data: {88'h0, 32'h44444444, 8'h80}, e_en: 3'd1, e_base: 8'h80, e_len: 8'd40};
      vecs[5] = '{name: "m6_max_comp", din: {{15{8'h40}}, 8'h00}, frc: 1'b0,
                  e_data: {8'h0, {15{7'h20}}, 7'h60, 8'h20}, e_en: 3'd6, e_base: 8'h20, e_len: 8'd120};
      vecs[6] = '{name: "m7_raw", din: {{15{8'h80}}, 8'h00}, frc: 1'b0,
                  e_data: {{15{8'h80}}, 8'h00}, e_en: 3'd7, e_base: 8'h00, e_len: 8'd128};
      vecs[7] = '{name: "outlier", din: {{15{8'h03}}, 8'h05}, frc: 1'b0,
                  e_data: {88'h0, 32'hFFFFFFFD, 8'h04}, e_en: 3'd1, e_base: 8'h04, e_len: 8'd40};
      vecs[8] = '{name: "zeros", din: {16{8'h00}}, frc: 1'b0,
                  e_data: {128'h0}, e_en: 3'd0, e_base: 8'h00, e_len: 8'd24};
      vecs[9] = '{name: "ones", din: {16{8'hFF}}, frc: 1'b0,
                  e_data: {120'h0, 8'hFF}, e_en: 3'd0, e_base: 8'hFF, e_len: 8'd24};

      // ---------------- reset state
      tick();
      tick();
      chk("reset out_valid", FW'(out_valid), FW'(0));
      chk("reset out_data", out_data, FW'(0));
      chk("reset out_en", FW'(out_en), FW'(0));
      chk("reset out_base", FW'(out_base), FW'(0));
      chk("reset out_len", FW'(out_len), FW'(0));
      chk("reset cnt_comp", FW'(cnt_comp), FW'(0));
      chk("reset cnt_raw", FW'(cnt_raw), FW'(0));
      chk("reset in_ready", FW'(in_ready), FW'(1));
      rst_n = 1'b1;
      tick();

      // ---------------- table vectors
      for (int i = 0; i < NV; i++) send_check(i);
      tick();
      chk("table out_valid drained", FW'(out_valid), FW'(0));
      chk("table cnt_comp", FW'(cnt_comp), FW'(exp_comp));
      chk("table cnt_raw", FW'(cnt_raw), FW'(exp_raw));

      // ---------------- 6-flit stream with out_ready low in cycles 4..8
      sent = 0;
      got = 0;
      stalled_prev = 1'b0;
      prev_data = '0;
      cyc = 0;
      while (cyc < 40 && got < 6) begin
         bv        = 8'(8'h30 + sent);
         in_valid  = (sent < 6);
         in_data   = {16{bv}};
         out_ready = !(cyc >= 4 && cyc <= 8);
         #1;
         if (out_valid && !out_ready) begin
            chk("stall in_ready", FW'(in_ready), FW'(0));
            if (stalled_prev) chk("stall hold out_data", out_data, prev_data);
         end
         stalled_prev = out_valid && !out_ready;
         prev_data    = out_data;
         in_hs        = in_valid && in_ready;
         out_hs       = out_valid && out_ready;
         if (out_hs) begin
            if (exp_q.size() == 0) chk("stream unexpected output", out_data, FW'(0) - FW'(1));
            else chk("stream order", out_data, exp_q.pop_front());
            got++;
            exp_comp++;
         end
         if (in_hs) begin
            exp_q.push_back({120'h0, bv});
            sent++;
         end
         tick();
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("stream delivered count", FW'(got), FW'(6));
      chk("stream queue empty", FW'(exp_q.size()), FW'(0));
      tick();
      tick();
      chk("stream no duplicate", FW'(out_valid), FW'(0));
      chk("stream cnt_comp", FW'(cnt_comp), FW'(exp_comp));

      // ---------------- reset with two flits in flight
      in_valid = 1'b1;
      in_data  = vecs[1].din;
      tick();
      in_data  = vecs[4].din;
      tick();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("midreset out_valid", FW'(out_valid), FW'(0));
      chk("midreset cnt_comp", FW'(cnt_comp), FW'(0));
      chk("midreset cnt_raw", FW'(cnt_raw), FW'(0));
      tick();
      tick();
      chk("midreset held out_valid", FW'(out_valid), FW'(0));
      rst_n = 1'b1;
      tick();
      send_check(5);
      tick();
      chk("post-reset cnt_comp", FW'(cnt_comp), FW'(1));
      chk("post-reset no stale flit", FW'(out_valid), FW'(0));

      // ---------------- stat_clr coincident with a raw delivery
      send_check(2);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      chk("clr-vs-hs cnt_raw", FW'(cnt_raw), FW'(0));
      chk("clr-vs-hs cnt_comp", FW'(cnt_comp), FW'(0));

      // ---------------- saturation: 65534 compressed flits, then 3 more
      out_ready = 1'b1;
      in_data   = {16{8'h40}};
      in_valid  = 1'b1;
      for (int k = 0; k < 65534; k++) tick();
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      chk("sat preload cnt_comp", FW'(cnt_comp), FW'(16'hFFFE));
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      chk("sat cnt_comp", FW'(cnt_comp), FW'(16'hFFFF));
      chk("sat cnt_raw", FW'(cnt_raw), FW'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
